// File: rtl/ab_input_cond_pkg.sv
// Shared definitions for the a/b input conditioning stage: debounce state
// encoding and the default tick counter width.
package ab_input_cond_pkg;

  localparam int N_DEFAULT = 19;

  localparam logic [2:0] ST_ZERO    = 3'd0;
  localparam logic [2:0] ST_WAIT1_1 = 3'd1;
  localparam logic [2:0] ST_WAIT1_2 = 3'd2;
  localparam logic [2:0] ST_WAIT1_3 = 3'd3;
  localparam logic [2:0] ST_ONE     = 3'd4;
  localparam logic [2:0] ST_WAIT0_1 = 3'd5;
  localparam logic [2:0] ST_WAIT0_2 = 3'd6;
  localparam logic [2:0] ST_WAIT0_3 = 3'd7;

  typedef enum logic [2:0] {
    ZERO    = ST_ZERO,
    WAIT1_1 = ST_WAIT1_1,
    WAIT1_2 = ST_WAIT1_2,
    WAIT1_3 = ST_WAIT1_3,
    ONE     = ST_ONE,
    WAIT0_1 = ST_WAIT0_1,
    WAIT0_2 = ST_WAIT0_2,
    WAIT0_3 = ST_WAIT0_3
  } db_state_t;

endpackage

// File: rtl/ab_input_cond_if.sv
// Signal bundle between the raw switch inputs and the conditioned a/b outputs,
// plus debug visibility of both debounce FSMs and the shared tick.
interface ab_input_cond_if;
  import ab_input_cond_pkg::*;

  // No valid/ready handshake: sw_* are free-running asynchronous levels and every
  // output is a level or single-cycle pulse that is valid on every clk edge.
  logic      sw_a;
  logic      sw_b;
  logic      a;
  logic      b;
  logic      a_tick;
  logic      b_tick;
  db_state_t state_a;
  db_state_t state_b;
  logic      m_tick;

  modport master (
    output sw_a, sw_b,
    input  a, b, a_tick, b_tick, state_a, state_b, m_tick
  );

  modport slave (
    input  sw_a, sw_b,
    output a, b, a_tick, b_tick, state_a, state_b, m_tick
  );
endinterface

// File: rtl/ab_input_cond_db_chan.sv
// One conditioning channel: 2-FF synchronizer, tick-driven debounce FSM and
// rising-edge detector on the debounced level.
module db_chan
  import ab_input_cond_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      sw,
  input  logic      m_tick,
  output logic      x,
  output logic      x_tick,
  output db_state_t state
);

  logic      sync_1;
  logic      sw_s;
  logic      x_d;
  db_state_t state_q;
  db_state_t state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sw_s   <= 1'b0;
    end else begin
      sync_1 <= sw;
      sw_s   <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ZERO;
    else          state_q <= state_d;
  end

  // An input mismatch always beats a coincident tick, so a bounce landing on the
  // tick edge can never complete a transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ZERO:    if (sw_s)        state_d = WAIT1_1;
      WAIT1_1: if (!sw_s)       state_d = ZERO;
               else if (m_tick) state_d = WAIT1_2;
      WAIT1_2: if (!sw_s)       state_d = ZERO;
               else if (m_tick) state_d = WAIT1_3;
      WAIT1_3: if (!sw_s)       state_d = ZERO;
               else if (m_tick) state_d = ONE;
      ONE:     if (!sw_s)       state_d = WAIT0_1;
      WAIT0_1: if (sw_s)        state_d = ONE;
               else if (m_tick) state_d = WAIT0_2;
      WAIT0_2: if (sw_s)        state_d = ONE;
               else if (m_tick) state_d = WAIT0_3;
      WAIT0_3: if (sw_s)        state_d = ONE;
               else if (m_tick) state_d = ZERO;
      default:                  state_d = ZERO;
    endcase
  end

  assign x = (state_q == ONE)     || (state_q == WAIT0_1) ||
             (state_q == WAIT0_2) || (state_q == WAIT0_3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) x_d <= 1'b0;
    else          x_d <= x;
  end

  assign x_tick = x & ~x_d;
  assign state  = state_q;

endmodule

// File: rtl/ab_input_cond.sv
// Two-channel input conditioner: one shared free-running tick counter feeding
// two independent debounce channels for the a and b operands.
module ab_input_cond
  import ab_input_cond_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic             clk,
  input logic             reset_n,
  ab_input_cond_if.slave  bus
);

  logic [N-1:0] cnt;
  logic         m_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt + 1'b1;
  end

  // Terminal count: one cycle in every 2^N.
  assign m_tick     = &cnt;
  assign bus.m_tick = m_tick;

  db_chan u_chan_a (
    .clk     (clk),
    .reset_n (reset_n),
    .sw      (bus.sw_a),
    .m_tick  (m_tick),
    .x       (bus.a),
    .x_tick  (bus.a_tick),
    .state   (bus.state_a)
  );

  db_chan u_chan_b (
    .clk     (clk),
    .reset_n (reset_n),
    .sw      (bus.sw_b),
    .m_tick  (m_tick),
    .x       (bus.b),
    .x_tick  (bus.b_tick),
    .state   (bus.state_b)
  );

endmodule

// File: tb/tb_ab_input_cond.sv
// Directed bench for ab_input_cond with N=3: reset, press/release latency,
// bounce rejection, tick collision and channel independence.
module tb_ab_input_cond;
  import ab_input_cond_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  ab_input_cond_if bus_if ();

  ab_input_cond #(.N(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Waits up to max_cyc negedges for a (ch=0) or b (ch=1) to reach lvl.
  // Returns the cycle count (0 if never) and number of tick pulses seen.
  task automatic wait_level(input int ch, input logic lvl, input int max_cyc,
                            output int lat, output int ticks);
    logic v;
    logic t;
    lat   = 0;
    ticks = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      v = (ch == 0) ? bus_if.a : bus_if.b;
      t = (ch == 0) ? bus_if.a_tick : bus_if.b_tick;
      if (t) ticks++;
      if (v == lvl && lat == 0) lat = i;
    end
  endtask

  int lat_a, lat_b, tk_a, tk_b, hi_a, hi_b, tick_at_rise_a, tick_at_rise_b;
  int found;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    bus_if.sw_a = 1'b0;
    bus_if.sw_b = 1'b0;
    cycles(3);
    check("rst_a", bus_if.a, 0);
    check("rst_b", bus_if.b, 0);
    check("rst_a_tick", bus_if.a_tick, 0);
    check("rst_b_tick", bus_if.b_tick, 0);
    check("rst_state_a", 32'(bus_if.state_a), 32'(ZERO));
    reset_n = 1'b1;
    cycles(4);

    // clean press on A, B idle
    bus_if.sw_a = 1'b1;
    lat_a = 0; tk_a = 0; hi_b = 0; tick_at_rise_a = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus_if.a_tick) tk_a++;
      if (bus_if.b || bus_if.b_tick) hi_b++;
      if (bus_if.a && lat_a == 0) begin
        lat_a = i;
        tick_at_rise_a = bus_if.a_tick;
      end
    end
    $display("press A latency %0d", lat_a);
    check("press_a_lat_in_19_27", (lat_a >= 19 && lat_a <= 27), 1);
    check("press_a_tick_at_rise", tick_at_rise_a, 1);
    check("press_a_tick_count", tk_a, 1);
    check("press_a_b_quiet", hi_b, 0);
    check("press_a_level_held", bus_if.a, 1);

    // release A
    bus_if.sw_a = 1'b0;
    wait_level(0, 1'b0, 40, lat_a, tk_a);
    $display("release A latency %0d", lat_a);
    check("release_a_lat_in_19_27", (lat_a >= 19 && lat_a <= 27), 1);
    check("release_a_no_tick", tk_a, 0);
    check("release_a_level", bus_if.a, 0);

    // bounce: toggle every 3 cycles for 30 cycles, then low
    hi_a = 0;
    for (int i = 0; i < 30; i++) begin
      bus_if.sw_a = ((i / 3) % 2 == 0);
      @(negedge clk);
      if (bus_if.a || bus_if.a_tick) hi_a++;
    end
    bus_if.sw_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.a || bus_if.a_tick) hi_a++;
    end
    check("bounce_a_quiet", hi_a, 0);

    // independence: A then B five cycles later
    bus_if.sw_a = 1'b1;
    lat_a = 0; lat_b = 0; tk_a = 0; tk_b = 0;
    tick_at_rise_a = 0; tick_at_rise_b = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 5) bus_if.sw_b = 1'b1;
      @(negedge clk);
      if (bus_if.a_tick) tk_a++;
      if (bus_if.b_tick) tk_b++;
      if (bus_if.a && lat_a == 0) begin
        lat_a = i;
        tick_at_rise_a = bus_if.a_tick;
      end
      if (bus_if.b && lat_b == 0) begin
        lat_b = i - 4;
        tick_at_rise_b = bus_if.b_tick;
      end
    end
    $display("indep latencies a=%0d b=%0d", lat_a, lat_b);
    check("indep_a_lat", (lat_a >= 19 && lat_a <= 27), 1);
    check("indep_b_lat", (lat_b >= 19 && lat_b <= 27), 1);
    check("indep_a_tick_count", tk_a, 1);
    check("indep_b_tick_count", tk_b, 1);
    check("indep_a_tick_at_rise", tick_at_rise_a, 1);
    check("indep_b_tick_at_rise", tick_at_rise_b, 1);

    // asynchronous reset mid-cycle with both inputs still high
    check("pre_reset_a_high", bus_if.a, 1);
    check("pre_reset_b_high", bus_if.b, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_a", bus_if.a, 0);
    check("async_rst_b", bus_if.b, 0);
    check("async_rst_a_tick", bus_if.a_tick, 0);
    check("async_rst_b_tick", bus_if.b_tick, 0);
    cycles(2);
    check("rst_held_a", bus_if.a, 0);
    reset_n = 1'b1;
    wait_level(0, 1'b1, 40, lat_a, tk_a);
    $display("post-reset A latency %0d", lat_a);
    check("post_rst_a_lat", (lat_a >= 19 && lat_a <= 27), 1);
    check("post_rst_a_tick_count", tk_a, 1);

    bus_if.sw_a = 1'b0;
    bus_if.sw_b = 1'b0;
    cycles(40);
    check("idle_a_low", bus_if.a, 0);
    check("idle_b_low", bus_if.b, 0);

    // tick collision: sw_a_s drops in WAIT1_3 exactly when m_tick fires
    bus_if.sw_a = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (bus_if.state_a == WAIT1_3) found = 1;
    end
    check("coll_reach_wait1_3", found, 1);
    cycles(5);
    bus_if.sw_a = 1'b0;
    cycles(2);
    check("coll_tick_now", bus_if.m_tick, 1);
    check("coll_still_wait1_3", 32'(bus_if.state_a), 32'(WAIT1_3));
    cycles(1);
    check("coll_to_zero", 32'(bus_if.state_a), 32'(ZERO));
    hi_a = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_if.a || bus_if.a_tick) hi_a++;
    end
    check("coll_a_quiet", hi_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
